// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared constants for the data-RAM port arbiter. Holds the
//                arbiter state encodings, the fixed debug byte select and a
//                4-bit saturating increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package arb_pkg;

    // Arbiter ownership states
    localparam logic [0:0] ARB_CPU = 1'b0;
    localparam logic [0:0] ARB_DBG = 1'b1;

    // Debug accesses are always full-word
    localparam logic [3:0] DBG_SEL = 4'b1111;

    // Increment that sticks at the all-ones value instead of wrapping
    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_port_mux
//  Description : 2:1 multiplexer of the RAM request bundle (address, write
//                data, byte select, read/write, extend type). The debug side
//                always presents a full-word select and a zero extend type.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_port_mux
    import arb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_sel_dbg,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    input  logic [3:0]        i_cpu_sel,
    input  logic              i_cpu_rw,
    input  logic              i_cpu_ext,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [31:0]       i_dbg_wdata,
    input  logic              i_dbg_rw,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_wdata,
    output logic [3:0]        o_sel,
    output logic              o_rw,
    output logic              o_ext
);

    assign o_addr  = i_sel_dbg ? i_dbg_addr  : i_cpu_addr;
    assign o_wdata = i_sel_dbg ? i_dbg_wdata : i_cpu_wdata;
    assign o_sel   = i_sel_dbg ? DBG_SEL     : i_cpu_sel;
    assign o_rw    = i_sel_dbg ? i_dbg_rw    : i_cpu_rw;
    assign o_ext   = i_sel_dbg ? 1'b0        : i_cpu_ext;

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Shares the single data-RAM port between the CPU MEM stage
//                and a debug/loader port. CPU has default priority; debug is
//                forced in after STARVE_LIMIT denied cycles and limited to
//                DBG_BURST beats per grant while the CPU is running.
//                Optional macro ARB_STATS_EN adds stall/beat counters.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_BITS    = 12,
    parameter int STARVE_LIMIT = 8,
    parameter int DBG_BURST    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic [ADDR_BITS-3:0] cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic [3:0]           cpu_sel,
    input  logic                 cpu_rw,
    input  logic                 cpu_ext,
    input  logic                 cpu_halt,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_stall,
    input  logic                 dbg_req,
    input  logic [ADDR_BITS-3:0] dbg_addr,
    input  logic [31:0]          dbg_wdata,
    input  logic                 dbg_rw,
    output logic                 dbg_gnt,
    output logic [31:0]          dbg_rdata,
    output logic                 dbg_rvalid,
    output logic [ADDR_BITS-3:0] ram_addr,
    output logic [31:0]          ram_data_in,
    output logic [3:0]           ram_sel,
    output logic                 ram_rw,
    output logic                 ram_extend_type,
    input  logic [31:0]          ram_data_out
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          dbg_beats
`endif
);

    localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);
    localparam logic [3:0] c_dbg_burst    = 4'(DBG_BURST);

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [7:0] r_starve_cnt;
    logic [3:0] r_beat_cnt;
    logic [3:0] w_beats_after;
    logic       w_starved;
    logic       w_dbg_gnt;
    logic       w_dbg_owns;
    logic       w_keep_dbg;
    logic       w_port_active;
    logic       w_mux_rw;
    logic [31:0] r_dbg_rdata;
    logic        r_dbg_rvalid;

    assign w_starved = (r_starve_cnt == c_starve_limit);

    // Grant decision; all combinational handshakes are held low during reset
    always_comb begin
        w_dbg_gnt = 1'b0;
        if (!rst) begin
            if (r_state == ARB_DBG) begin
                w_dbg_gnt = dbg_req;
            end else begin
                w_dbg_gnt = dbg_req & (~cpu_req | cpu_halt | w_starved);
            end
        end
    end

    // Debug drives the port while it holds the burst or is granted this cycle
    assign w_dbg_owns = ~rst & ((r_state == ARB_DBG) | w_dbg_gnt);

    // Beats completed in this burst once the current beat is counted; the
    // exit decision uses this so the CPU regains the port right after the
    // last allowed beat instead of one cycle later
    assign w_beats_after = (r_state == ARB_CPU) ? 4'd1 : sat_inc4(r_beat_cnt);
    assign w_keep_dbg    = w_dbg_gnt & (cpu_halt | ~cpu_req | (w_beats_after < c_dbg_burst));
    assign w_state_next  = w_keep_dbg ? ARB_DBG : ARB_CPU;

    // Ownership state, starvation counter and burst beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_CPU;
            r_starve_cnt <= 8'd0;
            r_beat_cnt   <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_beat_cnt <= w_keep_dbg ? w_beats_after : 4'd0;
            if (w_dbg_gnt || !dbg_req) begin
                r_starve_cnt <= 8'd0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    // Debug read data is captured at the grant edge and flagged for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dbg_rdata  <= 32'd0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_dbg_rvalid <= w_dbg_gnt & ~dbg_rw;
            if (w_dbg_gnt && !dbg_rw) begin
                r_dbg_rdata <= ram_data_out;
            end
        end
    end

    arb_port_mux #(
        .ADDR_W (ADDR_BITS-2)
    ) u_port_mux (
        .i_sel_dbg   (w_dbg_owns),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .i_cpu_sel   (cpu_sel),
        .i_cpu_rw    (cpu_rw),
        .i_cpu_ext   (cpu_ext),
        .i_dbg_addr  (dbg_addr),
        .i_dbg_wdata (dbg_wdata),
        .i_dbg_rw    (dbg_rw),
        .o_addr      (ram_addr),
        .o_wdata     (ram_data_in),
        .o_sel       (ram_sel),
        .o_rw        (w_mux_rw),
        .o_ext       (ram_extend_type)
    );

    // A write only reaches the RAM when the selected requester is actually active
    assign w_port_active = w_dbg_owns ? w_dbg_gnt : (cpu_req & ~rst);
    assign ram_rw        = w_mux_rw & w_port_active;

    assign cpu_rdata  = ram_data_out;
    assign cpu_stall  = cpu_req & w_dbg_owns;
    assign dbg_gnt    = w_dbg_gnt;
    assign dbg_rdata  = r_dbg_rdata;
    assign dbg_rvalid = r_dbg_rvalid;

`ifdef ARB_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_dbg_beats;

    // Free-running wrap-around counters of stalled cycles and debug beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_dbg_beats    <= 32'd0;
        end else begin
            if (cpu_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_dbg_gnt) begin
                r_dbg_beats <= r_dbg_beats + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign dbg_beats    = r_dbg_beats;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Self-checking bench for ram_port_arbiter with a word RAM
//                model, an ownership/starvation reference model and directed
//                scenarios with hand-computed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int ADDR_BITS    = 12;
    localparam int STARVE_LIMIT = 8;
    localparam int DBG_BURST    = 4;
    localparam int WA           = ADDR_BITS - 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0;
    logic [WA-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [3:0]    cpu_sel = '0;
    logic          cpu_rw = 1'b0;
    logic          cpu_ext = 1'b0;
    logic          cpu_halt = 1'b0;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req = 1'b0;
    logic [WA-1:0] dbg_addr = '0;
    logic [31:0]   dbg_wdata = '0;
    logic          dbg_rw = 1'b0;
    logic          dbg_gnt;
    logic [31:0]   dbg_rdata;
    logic          dbg_rvalid;
    logic [WA-1:0] ram_addr;
    logic [31:0]   ram_data_in;
    logic [3:0]    ram_sel;
    logic          ram_rw;
    logic          ram_extend_type;
    logic [31:0]   ram_data_out;
`ifdef ARB_STATS_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   dbg_beats;
`endif

    int checks   = 0;
    int failures = 0;

    ram_port_arbiter #(
        .ADDR_BITS    (ADDR_BITS),
        .STARVE_LIMIT (STARVE_LIMIT),
        .DBG_BURST    (DBG_BURST)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req         (cpu_req),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_sel         (cpu_sel),
        .cpu_rw          (cpu_rw),
        .cpu_ext         (cpu_ext),
        .cpu_halt        (cpu_halt),
        .cpu_rdata       (cpu_rdata),
        .cpu_stall       (cpu_stall),
        .dbg_req         (dbg_req),
        .dbg_addr        (dbg_addr),
        .dbg_wdata       (dbg_wdata),
        .dbg_rw          (dbg_rw),
        .dbg_gnt         (dbg_gnt),
        .dbg_rdata       (dbg_rdata),
        .dbg_rvalid      (dbg_rvalid),
        .ram_addr        (ram_addr),
        .ram_data_in     (ram_data_in),
        .ram_sel         (ram_sel),
        .ram_rw          (ram_rw),
        .ram_extend_type (ram_extend_type),
        .ram_data_out    (ram_data_out)
`ifdef ARB_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .dbg_beats       (dbg_beats)
`endif
    );

    always #5 clk = ~clk;

    // Data RAM: combinational read, byte-selected write on the clock edge
    logic [31:0] ram_mem [0:(1<<WA)-1] = '{default: 32'h0};
    assign ram_data_out = ram_mem[ram_addr];

    always @(posedge clk) begin
        if (ram_rw) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_sel[b]) ram_mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the port, how long debug has waited, how
    // many beats the current debug burst has used, and a shadow memory.
    // ------------------------------------------------------------------
    logic [31:0] m_mem [0:(1<<WA)-1] = '{default: 32'h0};
    bit          m_dbg_owner = 1'b0;
    int          m_denied    = 0;
    int          m_beats     = 0;
    logic [31:0] m_rdata     = 32'h0;
    bit          m_rvalid    = 1'b0;
    int          m_stalls    = 0;
    int          m_grants    = 0;

    always @(negedge clk) begin : compare_proc
        bit          e_gnt;
        bit          e_owns;
        bit          e_stall;
        bit          e_rw;
        logic [WA-1:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_sel;
        bit          e_ext;
        int          done;
        if (rst) begin
            check("rst_dbg_gnt", 32'(dbg_gnt), 32'h0);
            check("rst_cpu_stall", 32'(cpu_stall), 32'h0);
            check("rst_ram_rw", 32'(ram_rw), 32'h0);
            check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
            check("rst_dbg_rdata", dbg_rdata, 32'h0);
`ifdef ARB_STATS_EN
            check("rst_stall_cycles", stall_cycles, 32'h0);
            check("rst_dbg_beats", dbg_beats, 32'h0);
`endif
            m_dbg_owner = 1'b0;
            m_denied    = 0;
            m_beats     = 0;
            m_rdata     = 32'h0;
            m_rvalid    = 1'b0;
            m_stalls    = 0;
            m_grants    = 0;
        end else begin
            check("m_dbg_rdata", dbg_rdata, m_rdata);
            check("m_dbg_rvalid", 32'(dbg_rvalid), 32'(m_rvalid));
`ifdef ARB_STATS_EN
            check("m_stall_cycles", stall_cycles, 32'(m_stalls));
            check("m_dbg_beats", dbg_beats, 32'(m_grants));
`endif
            e_gnt   = dbg_req && (m_dbg_owner || !cpu_req || cpu_halt || m_denied >= STARVE_LIMIT);
            e_owns  = m_dbg_owner || e_gnt;
            e_stall = cpu_req && e_owns;
            if (e_owns) begin
                e_addr = dbg_addr; e_wdata = dbg_wdata; e_sel = 4'hF; e_ext = 1'b0;
                e_rw   = e_gnt && dbg_rw;
            end else begin
                e_addr = cpu_addr; e_wdata = cpu_wdata; e_sel = cpu_sel; e_ext = cpu_ext;
                e_rw   = cpu_req && cpu_rw;
            end
            check("m_dbg_gnt", 32'(dbg_gnt), 32'(e_gnt));
            check("m_cpu_stall", 32'(cpu_stall), 32'(e_stall));
            check("m_ram_addr", 32'(ram_addr), 32'(e_addr));
            check("m_ram_rw", 32'(ram_rw), 32'(e_rw));
            check("m_ram_sel", 32'(ram_sel), 32'(e_sel));
            check("m_ram_ext", 32'(ram_extend_type), 32'(e_ext));
            if (e_rw) check("m_ram_data_in", ram_data_in, e_wdata);
            check("m_cpu_rdata", cpu_rdata, m_mem[e_addr]);

            // advance the model by one clock
            m_rvalid = e_gnt && !dbg_rw;
            if (m_rvalid) m_rdata = m_mem[dbg_addr];
            if (e_rw) begin
                for (int b = 0; b < 4; b++) begin
                    if (e_sel[b]) m_mem[e_addr][8*b +: 8] = e_wdata[8*b +: 8];
                end
            end
            if (e_gnt) begin
                done        = m_dbg_owner ? m_beats + 1 : 1;
                m_dbg_owner = cpu_halt || !cpu_req || (done < DBG_BURST);
                m_beats     = m_dbg_owner ? done : 0;
            end else begin
                m_dbg_owner = 1'b0;
                m_beats     = 0;
            end
            if (e_gnt || !dbg_req) m_denied = 0;
            else if (m_denied < STARVE_LIMIT) m_denied = m_denied + 1;
            if (e_stall) m_stalls++;
            if (e_gnt) m_grants++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        cpu_req = 1'b0; cpu_rw = 1'b0; cpu_halt = 1'b0; cpu_sel = 4'h0; cpu_ext = 1'b0;
        dbg_req = 1'b0; dbg_rw = 1'b0;
    endtask

    task automatic do_reset();
        next_cycle();
        go_idle();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        int n_stall;
        int n_gnt;
        int first_gnt;
        int second_gnt;

        // Reset state with debug already requesting
        #1;
        rst     = 1'b1;
        dbg_req = 1'b1;
        #1;
        check("reset_dbg_gnt", 32'(dbg_gnt), 32'h0);
        check("reset_cpu_stall", 32'(cpu_stall), 32'h0);
        check("reset_ram_rw", 32'(ram_rw), 32'h0);
        check("reset_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
        check("reset_dbg_rdata", dbg_rdata, 32'h0);
        dbg_req = 1'b0;
        next_cycle();
        rst = 1'b0;

        // 1: CPU-only stores then loads
        do_reset();
        n_stall = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            cpu_req  = 1'b1;
            cpu_ext  = i[0];
            cpu_sel  = (i % 2 == 0) ? 4'hF : 4'h3;
            if (i < 10) begin
                cpu_rw    = 1'b1;
                cpu_addr  = WA'(i * 3);
                cpu_wdata = 32'h1000_0000 + 32'(i);
            end else begin
                cpu_rw   = 1'b0;
                cpu_addr = WA'((i - 10) * 3);
            end
            #1;
            if (cpu_stall) n_stall++;
            if (i == 10) check("t1_load_word0", cpu_rdata, 32'h1000_0000);
            if (i == 11) check("t1_load_word3", cpu_rdata, 32'h0000_0001);
        end
        check("t1_no_stall", 32'(n_stall), 32'h0);

        // 2: starvation forces debug in, burst limited to DBG_BURST beats
        do_reset();
        n_stall = 0; n_gnt = 0; first_gnt = 0; second_gnt = 0;
        for (int c = 1; c <= 22; c++) begin
            next_cycle();
            cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = WA'(0); cpu_halt = 1'b0;
            dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = WA'(3);
            #1;
            if (c <= 20 && dbg_gnt) n_gnt++;
            if (c <= 20 && cpu_stall) n_stall++;
            if (dbg_gnt && first_gnt == 0) first_gnt = c;
            else if (dbg_gnt && c > 13 && second_gnt == 0) second_gnt = c;
            if (c == 13) begin
                check("t2_stall_after_burst", 32'(cpu_stall), 32'h0);
`ifdef ARB_STATS_EN
                check("t6_stall_cycles", stall_cycles, 32'd4);
                check("t6_dbg_beats", dbg_beats, 32'd4);
`endif
            end
        end
        check("t2_first_grant_cycle", 32'(first_gnt), 32'd9);
        check("t2_beats", 32'(n_gnt), 32'd4);
        check("t2_stalls", 32'(n_stall), 32'd4);
        check("t2_second_grant_cycle", 32'(second_gnt), 32'd21);

        // 3: halted CPU, unlimited debug burst, write then read back
        do_reset();
        n_gnt = 0;
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = WA'(0); cpu_halt = 1'b1;
            dbg_req = 1'b1;
            if (c == 0) begin
                dbg_rw = 1'b1; dbg_addr = WA'(5); dbg_wdata = 32'hDEAD_BEEF;
            end else if (c < 6) begin
                dbg_rw = 1'b1; dbg_addr = WA'(5 + c); dbg_wdata = 32'(c);
            end else begin
                dbg_rw = 1'b0; dbg_addr = WA'(5);
            end
            #1;
            if (dbg_gnt) n_gnt++;
        end
        check("t3_all_granted", 32'(n_gnt), 32'd7);
        next_cycle();
        dbg_req = 1'b0;
        #1;
        check("t3_rvalid", 32'(dbg_rvalid), 32'h1);
        check("t3_rdata", dbg_rdata, 32'hDEAD_BEEF);
        next_cycle();
        #1;
        check("t3_rvalid_pulse", 32'(dbg_rvalid), 32'h0);

        // 4: simultaneous requests, CPU wins
        do_reset();
        next_cycle();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = WA'(7);
        dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = WA'(9);
        #1;
        check("t4_dbg_gnt", 32'(dbg_gnt), 32'h0);
        check("t4_ram_addr", 32'(ram_addr), 32'd7);
        check("t4_cpu_stall", 32'(cpu_stall), 32'h0);
        next_cycle();
        #1;
        check("t4_starve_cnt", 32'(dut.r_starve_cnt), 32'd1);

        // 5: reset mid-burst aborts immediately
        do_reset();
        next_cycle();
        cpu_req = 1'b0; cpu_halt = 1'b0;
        dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = WA'(5);
        #1;
        check("t5_beat1_gnt", 32'(dbg_gnt), 32'h1);
        next_cycle();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = WA'(2);
        #1;
        check("t5_beat2_gnt", 32'(dbg_gnt), 32'h1);
        check("t5_beat2_stall", 32'(cpu_stall), 32'h1);
        check("t5_beat1_rdata", dbg_rdata, 32'hDEAD_BEEF);
        #1;
        rst = 1'b1;
        #1;
        check("t5_async_gnt", 32'(dbg_gnt), 32'h0);
        check("t5_async_stall", 32'(cpu_stall), 32'h0);
        check("t5_async_ram_rw", 32'(ram_rw), 32'h0);
        check("t5_async_rvalid", 32'(dbg_rvalid), 32'h0);
        check("t5_async_rdata", dbg_rdata, 32'h0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("t5_cpu_wins_after_reset", 32'(dbg_gnt), 32'h0);
        check("t5_ram_addr_cpu", 32'(ram_addr), 32'd2);
        check("t5_no_rvalid", 32'(dbg_rvalid), 32'h0);
        next_cycle();
        go_idle();
        next_cycle();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
